// File: rtl/dmem_responder_if.sv
// Load/store bus between the core datapath and dmem_responder, plus the TX drain port.
interface dmem_responder_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wr_en;
   logic        rd_en;
   logic [2:0]  funct3;
   logic [31:0] rdata;
   logic        misaligned;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   modport master (
      output addr, wdata, wr_en, rd_en, funct3, tx_ready,
      input  rdata, misaligned, tx_valid, tx_data
   );

   modport slave (
      input  addr, wdata, wr_en, rd_en, funct3, tx_ready,
      output rdata, misaligned, tx_valid, tx_data
   );
endinterface

// File: rtl/dmem_responder.sv
// Data memory responder: byte-lane stores, extended loads, misalign detect.
// Define DMEM_MMIO_EN to build the I/O window (TX FIFO, status, cycle counter).
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   logic [31:0]   r_mem [DEPTH_WORDS];
   logic [AW-1:0] w_idx;
   logic          w_byte, w_half, w_word;
   logic          w_mmio, w_misal_raw;
   logic [31:0]   w_word_rd, w_shift, w_ram_rd, w_mmio_rd;
   logic [15:0]   w_half_rd;
   logic          w_ram_we;
   logic [3:0]    w_be;
   logic [31:0]   w_wlanes;

   assign w_idx  = bus.addr[AW+1:2];
   assign w_byte = (bus.funct3[1:0] == 2'b00);
   assign w_half = (bus.funct3[1:0] == 2'b01);
   assign w_word = bus.funct3[1];

`ifdef DMEM_MMIO_EN
   assign w_mmio = (bus.addr[31:4] == MMIO_BASE[31:4]);
`else
   assign w_mmio = 1'b0;
`endif

   // I/O registers need word alignment regardless of the requested size.
   always_comb begin
      w_misal_raw = 1'b0;
      if (w_mmio)
         w_misal_raw = |bus.addr[1:0];
      else
         w_misal_raw = (w_half & bus.addr[0]) | (w_word & (|bus.addr[1:0]));
   end

   assign bus.misaligned = (bus.wr_en | bus.rd_en) & w_misal_raw;

   assign w_word_rd = r_mem[w_idx];
   assign w_shift   = w_word_rd >> {bus.addr[1:0], 3'b000};
   assign w_half_rd = bus.addr[1] ? w_word_rd[31:16] : w_word_rd[15:0];

   always_comb begin
      w_ram_rd = w_word_rd;
      if (w_byte)
         w_ram_rd = {{24{~bus.funct3[2] & w_shift[7]}}, w_shift[7:0]};
      else if (w_half)
         w_ram_rd = {{16{~bus.funct3[2] & w_half_rd[15]}}, w_half_rd};
   end

   assign bus.rdata = (bus.rd_en & ~w_misal_raw) ? (w_mmio ? w_mmio_rd : w_ram_rd) : 32'd0;

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      w_be     = 4'b1111;
      w_wlanes = bus.wdata;
      if (w_byte) begin
         w_be     = 4'b0001 << bus.addr[1:0];
         w_wlanes = {4{bus.wdata[7:0]}};
      end else if (w_half) begin
         w_be     = bus.addr[1] ? 4'b1100 : 4'b0011;
         w_wlanes = {2{bus.wdata[15:0]}};
      end
   end

   assign w_ram_we = bus.wr_en & ~w_mmio & ~w_misal_raw & ~rst;

   always_ff @(posedge clk) begin
      if (w_ram_we)
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
   end

`ifdef DMEM_MMIO_EN
   logic [7:0]  r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [PW:0] r_count;
   logic        r_ovf;
   logic [31:0] r_cycles;
   logic        w_mmio_ok, w_push, w_cyc_clr, w_stat_rd;
   logic        w_full, w_empty, w_pop, w_acc;
   logic [31:0] w_status;

   assign w_mmio_ok = w_mmio & ~w_misal_raw;
   assign w_push    = bus.wr_en & w_mmio_ok & (bus.addr[3:2] == 2'd0);
   assign w_cyc_clr = bus.wr_en & w_mmio_ok & (bus.addr[3:2] == 2'd2);
   assign w_stat_rd = bus.rd_en & w_mmio_ok & (bus.addr[3:2] == 2'd1);

   assign w_full  = (r_count == (PW+1)'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = ~w_empty & bus.tx_ready;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign w_acc   = w_push & (~w_full | w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_cycles <= 32'd0;
      end else begin
         if (w_acc) r_wptr <= r_wptr + PW'(1);
         if (w_pop) r_rptr <= r_rptr + PW'(1);
         r_count <= r_count + (PW+1)'(w_acc) - (PW+1)'(w_pop);
         if (w_push & ~w_acc)
            r_ovf <= 1'b1;
         else if (w_stat_rd)
            r_ovf <= 1'b0;
         r_cycles <= w_cyc_clr ? 32'd0 : r_cycles + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc & ~rst) r_fifo[r_wptr] <= bus.wdata[7:0];
   end

   assign bus.tx_valid = ~w_empty;
   assign bus.tx_data  = w_empty ? 8'd0 : r_fifo[r_rptr];
   assign w_status     = {24'd0, 4'(r_count), 1'b0, r_ovf, w_empty, w_full};

   always_comb begin
      w_mmio_rd = 32'd0;
      case (bus.addr[3:2])
         2'd1:    w_mmio_rd = w_status;
         2'd2:    w_mmio_rd = r_cycles;
         default: w_mmio_rd = 32'd0;
      endcase
   end
`else
   logic        w_unused;
   logic [31:0] w_cfg_unused;

   assign bus.tx_valid = 1'b0;
   assign bus.tx_data  = 8'd0;
   assign w_mmio_rd    = 32'd0;
   assign w_unused     = ^{bus.addr[31:AW+2], bus.tx_ready};
   assign w_cfg_unused = 32'(FIFO_DEPTH) ^ MMIO_BASE;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expectations, a negedge monitor checks them.
module tb_dmem_responder;
   localparam logic [31:0] BASE = 32'h8000_0000;

   typedef struct {
      string       nm;
      logic [31:0] rd;
      logic        mis;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t exp_q[$];
   logic [7:0] tx_q[$];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_responder_if bus();

   dmem_responder #(
      .DEPTH_WORDS(256),
      .FIFO_DEPTH(4),
      .MMIO_BASE(BASE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic op(input string nm, input bit we, input bit re, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] erd, input bit emis);
      exp_t e;
      e.nm = nm; e.rd = erd; e.mis = emis;
      exp_q.push_back(e);
      bus.wr_en = we; bus.rd_en = re; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
      @(posedge clk); #1;
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Monitor: every bus access and every TX handshake consumes one expectation.
   always @(negedge clk) begin
      exp_t e;
      logic [7:0] t;
      if (bus.wr_en || bus.rd_en) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_access actual=%0h expected=none", bus.rdata);
         end else begin
            e = exp_q.pop_front();
            chk({e.nm, "_rdata"}, bus.rdata, e.rd);
            chk({e.nm, "_mis"}, 32'(bus.misaligned), 32'(e.mis));
         end
      end
      if (bus.tx_valid && bus.tx_ready) begin
         if (tx_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_tx actual=%0h expected=none", bus.tx_data);
         end else begin
            t = tx_q.pop_front();
            chk("tx_data", 32'(bus.tx_data), 32'(t));
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      bus.addr = '0; bus.wdata = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      bus.funct3 = 3'b010; bus.tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      rst = 1'b0;

      op("sw10",   1, 0, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 0);
      op("lb11",   0, 1, 3'b000, 32'h11, 32'd0, 32'hFFFFFFBE, 0);
      op("lbu11",  0, 1, 3'b100, 32'h11, 32'd0, 32'h000000BE, 0);
      op("lh12",   0, 1, 3'b001, 32'h12, 32'd0, 32'hFFFFDEAD, 0);
      op("lhu12",  0, 1, 3'b101, 32'h12, 32'd0, 32'h0000DEAD, 0);
      op("lw10",   0, 1, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 0);
      op("sh13",   1, 0, 3'b001, 32'h13, 32'h1234, 32'd0, 1);
      op("lw10b",  0, 1, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 0);
      op("lw12",   0, 1, 3'b010, 32'h12, 32'd0, 32'd0, 1);
      op("lhu11",  0, 1, 3'b101, 32'h11, 32'd0, 32'd0, 1);
      op("sb13",   1, 0, 3'b000, 32'h13, 32'hFFFFFFA5, 32'd0, 0);
      op("lw10c",  0, 1, 3'b010, 32'h10, 32'd0, 32'hA5ADBEEF, 0);
      op("lb13",   0, 1, 3'b000, 32'h13, 32'd0, 32'hFFFFFFA5, 0);
      op("sw14",   1, 0, 3'b010, 32'h14, 32'h11223344, 32'd0, 0);
      op("sh14",   1, 0, 3'b001, 32'h14, 32'h5555ABCD, 32'd0, 0);
      op("lw14",   0, 1, 3'b010, 32'h14, 32'd0, 32'h1122ABCD, 0);
      op("lhu16",  0, 1, 3'b101, 32'h16, 32'd0, 32'h00001122, 0);
      op("alias",  0, 1, 3'b010, 32'h410, 32'd0, 32'hA5ADBEEF, 0);
      op("f3_011", 0, 1, 3'b011, 32'h10, 32'd0, 32'hA5ADBEEF, 0);
      op("f3_110", 0, 1, 3'b110, 32'h10, 32'd0, 32'hA5ADBEEF, 0);
      op("f3_111", 0, 1, 3'b111, 32'h12, 32'd0, 32'd0, 1);

      bus.addr = 32'h13; bus.funct3 = 3'b010; #1;
      chk("idle_mis", 32'(bus.misaligned), 32'd0);
      chk("idle_rdata", bus.rdata, 32'd0);

      op("sw18", 1, 0, 3'b010, 32'h18, 32'h5, 32'd0, 0);
      rst = 1'b1;
      op("sw18_rst", 1, 0, 3'b010, 32'h18, 32'h99999999, 32'd0, 0);
      rst = 1'b0;
      op("lw18", 0, 1, 3'b010, 32'h18, 32'd0, 32'h5, 0);

`ifndef DMEM_MMIO_EN
      bus.tx_ready = 1'b1;
      op("sw_base", 1, 0, 3'b010, BASE, 32'hCAFEF00D, 32'd0, 0);
      op("lw_base", 0, 1, 3'b010, BASE, 32'd0, 32'hCAFEF00D, 0);
      for (int i = 0; i < 3; i++) begin
         chk("nommio_tx_valid", 32'(bus.tx_valid), 32'd0);
         idle(1);
      end
      bus.tx_ready = 1'b0;
`else
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         op("push", 1, 0, 3'b010, BASE, 32'h41 + 32'(i), 32'd0, 0);
         if (i < 4) tx_q.push_back(8'h41 + 8'(i));
      end
      op("stat_ovf",   0, 1, 3'b010, BASE + 32'h4, 32'd0, 32'h45, 0);
      op("stat_clr",   0, 1, 3'b010, BASE + 32'h4, 32'd0, 32'h41, 0);
      op("rd_txdata",  0, 1, 3'b010, BASE, 32'd0, 32'd0, 0);
      op("rd_offc",    0, 1, 3'b010, BASE + 32'hC, 32'd0, 32'd0, 0);
      op("mmio_lb",    0, 1, 3'b000, BASE + 32'h5, 32'd0, 32'd0, 1);
      op("mmio_sb",    1, 0, 3'b000, BASE + 32'h1, 32'h77, 32'd0, 1);
      bus.tx_ready = 1'b1;
      op("push_full_pop", 1, 0, 3'b010, BASE, 32'h55, 32'd0, 0);
      tx_q.push_back(8'h55);
      bus.tx_ready = 1'b0;
      op("stat_full", 0, 1, 3'b010, BASE + 32'h4, 32'd0, 32'h41, 0);

      bus.tx_ready = 1'b1;
      n = 0;
      while (bus.tx_valid && n < 20) begin idle(1); n++; end
      bus.tx_ready = 1'b0;
      chk("drain_cycles", 32'(n), 32'd4);
      chk("drain_left", 32'(tx_q.size()), 32'd0);
      op("stat_empty", 0, 1, 3'b010, BASE + 32'h4, 32'd0, 32'h02, 0);

      op("cyc_clr", 1, 0, 3'b010, BASE + 32'h8, 32'h123, 32'd0, 0);
      idle(10);
      op("cyc_rd", 0, 1, 3'b010, BASE + 32'h8, 32'd0, 32'd10, 0);

      for (int i = 0; i < 3; i++) begin
         op("push6", 1, 0, 3'b010, BASE, 32'h61 + 32'(i), 32'd0, 0);
         tx_q.push_back(8'h61 + 8'(i));
      end
      bus.tx_ready = 1'b1;
      idle(1);
      rst = 1'b1; bus.tx_ready = 1'b0;
      idle(1);
      rst = 1'b0;
      chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("midrst_tx_data", 32'(bus.tx_data), 32'd0);
      op("cyc_after_rst", 0, 1, 3'b010, BASE + 32'h8, 32'd0, 32'd0, 0);
      tx_q.delete();
      op("stat_after_rst", 0, 1, 3'b010, BASE + 32'h4, 32'd0, 32'h02, 0);

      bus.tx_ready = 1'b1;
      op("push_empty_ready", 1, 0, 3'b010, BASE, 32'h70, 32'd0, 0);
      tx_q.push_back(8'h70);
      idle(2);
      bus.tx_ready = 1'b0;
      chk("empty_push_left", 32'(tx_q.size()), 32'd0);
`endif

      idle(2);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
